// File: rtl/johnson_phase_decoder_if.sv
// johnson_phase_decoder_if
//   Bundle between the upstream Johnson counter / controller and the decoder.
//   master : drives Q_in, En, ErrClr; observes the decoded outputs.
//   slave  : the decoder side (samples inputs, drives all outputs).
//   REV_W  : width of RevCnt; must match the decoder's REV_W.
interface johnson_phase_decoder_if #(
    parameter int REV_W = 8
);
    logic [4:0]       Q_in;
    logic             En;
    logic             ErrClr;
    logic [9:0]       Phase;
    logic [3:0]       PhaseIdx;
    logic             Valid;
    logic             Wrap;
    logic [REV_W-1:0] RevCnt;
    logic             IllegalErr;
    logic             StepErr;

    modport master (
        output Q_in, En, ErrClr,
        input  Phase, PhaseIdx, Valid, Wrap, RevCnt, IllegalErr, StepErr
    );

    modport slave (
        input  Q_in, En, ErrClr,
        output Phase, PhaseIdx, Valid, Wrap, RevCnt, IllegalErr, StepErr
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//   Decodes the 5-bit Johnson ring counter state into a registered one-hot
//   10-phase vector and binary index, counts completed revolutions and keeps
//   sticky integrity flags.
//
//   Ports:
//     Clk        clock (same domain as the upstream counter)
//     Reset      asynchronous, active-high reset
//     bus.slave  Q_in/En/ErrClr in; Phase, PhaseIdx, Valid, Wrap, RevCnt,
//                IllegalErr, StepErr out (all registered)
//
//   Build option: define JDEC_STEP_CHECK_EN to compile in the out-of-sequence
//   step checker; otherwise StepErr is tied to 0.
module johnson_phase_decoder #(
    parameter int REV_W = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    johnson_phase_decoder_if.slave  bus
);

    logic             legal;
    logic [3:0]       idx;
    logic             wrap_now;
    logic             ill_now;

    logic [9:0]       phase_q;
    logic [3:0]       idx_q;
    logic             valid_q;
    logic             wrap_q;
    logic [REV_W-1:0] rev_q;
    logic             ill_err_q;

    // Code -> index lookup; anything outside the 10-state ring is illegal.
    always_comb begin
        legal = 1'b1;
        idx   = 4'd0;
        case (bus.Q_in)
            5'b00000: idx = 4'd0;
            5'b00001: idx = 4'd1;
            5'b00011: idx = 4'd2;
            5'b00111: idx = 4'd3;
            5'b01111: idx = 4'd4;
            5'b11111: idx = 4'd5;
            5'b11110: idx = 4'd6;
            5'b11100: idx = 4'd7;
            5'b11000: idx = 4'd8;
            5'b10000: idx = 4'd9;
            default: begin
                legal = 1'b0;
                idx   = 4'hF;
            end
        endcase
    end

    // idx_q/valid_q double as the previous-sample register: they update on
    // exactly the same enabled edges, so a separate copy would be identical.
    assign wrap_now = bus.En & valid_q & (idx_q == 4'd9) & legal & (idx == 4'd0);
    assign ill_now  = bus.En & ~legal;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            rev_q     <= '0;
            ill_err_q <= 1'b0;
        end else begin
            wrap_q    <= wrap_now;
            // Set has priority over clear so a same-edge error is never lost.
            ill_err_q <= (ill_err_q & ~bus.ErrClr) | ill_now;
            if (bus.En) begin
                phase_q <= legal ? (10'b1 << idx) : 10'b0;
                idx_q   <= idx;
                valid_q <= legal;
                if (wrap_now)
                    rev_q <= rev_q + REV_W'(1);
            end
        end
    end

`ifdef JDEC_STEP_CHECK_EN
    logic       step_err_q;
    logic [3:0] succ;
    logic       step_bad;

    // Only checked against a legal previous sample: the first sample after
    // reset or after an illegal code resynchronises silently.
    assign succ     = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
    assign step_bad = bus.En & valid_q & legal & (idx != idx_q) & (idx != succ);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            step_err_q <= 1'b0;
        else
            step_err_q <= (step_err_q & ~bus.ErrClr) | step_bad;
    end

    assign bus.StepErr = step_err_q;
`else
    assign bus.StepErr = 1'b0;
`endif

    assign bus.Phase      = phase_q;
    assign bus.PhaseIdx   = idx_q;
    assign bus.Valid      = valid_q;
    assign bus.Wrap       = wrap_q;
    assign bus.RevCnt     = rev_q;
    assign bus.IllegalErr = ill_err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder. Two instances share stimulus:
// dut (REV_W=8) for the main checks and dut2 (REV_W=2) for counter rollover.
module tb_johnson_phase_decoder;

`ifdef JDEC_STEP_CHECK_EN
    localparam logic STEP_EXP = 1'b1;
`else
    localparam logic STEP_EXP = 1'b0;
`endif

    logic Clk;
    logic Reset;
    int   nvec = 0;
    int   nerr = 0;

    johnson_phase_decoder_if #(.REV_W(8)) b  ();
    johnson_phase_decoder_if #(.REV_W(2)) b2 ();

    assign b2.Q_in   = b.Q_in;
    assign b2.En     = b.En;
    assign b2.ErrClr = b.ErrClr;

    johnson_phase_decoder #(.REV_W(8)) dut  (.Clk(Clk), .Reset(Reset), .bus(b));
    johnson_phase_decoder #(.REV_W(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(b2));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [4:0] jc(input int k);
        case (k)
            0: return 5'b00000;
            1: return 5'b00001;
            2: return 5'b00011;
            3: return 5'b00111;
            4: return 5'b01111;
            5: return 5'b11111;
            6: return 5'b11110;
            7: return 5'b11100;
            8: return 5'b11000;
            default: return 5'b10000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [4:0] q, input logic en, input logic clr);
        @(negedge Clk);
        b.Q_in   = q;
        b.En     = en;
        b.ErrClr = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 32'(b.Phase), 0);
        chk({tag, ".idx"},   32'(b.PhaseIdx), 0);
        chk({tag, ".valid"}, 32'(b.Valid), 0);
        chk({tag, ".wrap"},  32'(b.Wrap), 0);
        chk({tag, ".rev"},   32'(b.RevCnt), 0);
        chk({tag, ".ill"},   32'(b.IllegalErr), 0);
        chk({tag, ".step"},  32'(b.StepErr), 0);
    endtask

    initial begin
        Reset    = 1'b0;
        b.Q_in   = 5'b0;
        b.En     = 1'b0;
        b.ErrClr = 1'b0;
        #1 Reset = 1'b1;
        #2;
        chk_zero("reset");

        @(negedge Clk);
        Reset = 1'b0;

        // Free-running counter, 25 samples; wraps at samples 10 and 20.
        for (int i = 0; i < 25; i++) begin
            step(jc(i % 10), 1'b1, 1'b0);
            chk("run.idx",   32'(b.PhaseIdx), 32'(i % 10));
            chk("run.phase", 32'(b.Phase), 32'(1) << (i % 10));
            chk("run.wrap",  32'(b.Wrap), 32'((i == 10) || (i == 20)));
        end
        chk("run.rev",  32'(b.RevCnt), 2);
        chk("run.ill",  32'(b.IllegalErr), 0);
        chk("run.step", 32'(b.StepErr), 0);

        // Illegal code, then resync on a legal one.
        step(5'b01010, 1'b1, 1'b0);
        chk("ill.phase", 32'(b.Phase), 0);
        chk("ill.idx",   32'(b.PhaseIdx), 32'hF);
        chk("ill.valid", 32'(b.Valid), 0);
        chk("ill.err",   32'(b.IllegalErr), 1);
        step(5'b00111, 1'b1, 1'b0);
        chk("resync.idx",   32'(b.PhaseIdx), 3);
        chk("resync.valid", 32'(b.Valid), 1);
        chk("resync.step",  32'(b.StepErr), 0);

        // Skip 1 -> 3 after a clean resync on index 1.
        step(5'b01010, 1'b1, 1'b0);
        step(5'b00001, 1'b1, 1'b1);
        chk("skip.pre.ill",  32'(b.IllegalErr), 0);
        chk("skip.pre.step", 32'(b.StepErr), 0);
        step(5'b00111, 1'b1, 1'b0);
        chk("skip.idx",  32'(b.PhaseIdx), 3);
        chk("skip.step", 32'(b.StepErr), 32'(STEP_EXP));
        step(5'b00111, 1'b1, 1'b1);
        chk("skip.clr", 32'(b.StepErr), 0);

        // Land on index 1 with clean flags, then hold En low.
        step(5'b01010, 1'b1, 1'b0);
        step(5'b00001, 1'b1, 1'b1);
        step(5'b00000, 1'b0, 1'b0);
        step(5'b01010, 1'b0, 1'b0);
        step(5'b11111, 1'b0, 1'b0);
        step(5'b00111, 1'b0, 1'b0);
        chk("hold.idx",   32'(b.PhaseIdx), 1);
        chk("hold.phase", 32'(b.Phase), 32'h2);
        chk("hold.valid", 32'(b.Valid), 1);
        chk("hold.wrap",  32'(b.Wrap), 0);
        chk("hold.rev",   32'(b.RevCnt), 2);
        chk("hold.ill",   32'(b.IllegalErr), 0);
        step(5'b00011, 1'b1, 1'b0);
        chk("rep1.idx", 32'(b.PhaseIdx), 2);
        step(5'b00011, 1'b1, 1'b0);
        chk("rep2.idx",  32'(b.PhaseIdx), 2);
        chk("rep2.step", 32'(b.StepErr), 0);

        // Clear and set on the same edge: set wins; plain clear next edge.
        step(5'b01010, 1'b1, 1'b1);
        chk("setclr.ill", 32'(b.IllegalErr), 1);
        step(5'b00011, 1'b1, 1'b1);
        chk("clr.ill", 32'(b.IllegalErr), 0);
        b.ErrClr = 1'b0;

        // Fresh reset, then 41 samples for 4 revolutions on the 2-bit counter.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 41; i++) begin
            step(jc(i % 10), 1'b1, 1'b0);
            if (i == 10) chk("rev2.1", 32'(b2.RevCnt), 1);
            if (i == 20) chk("rev2.2", 32'(b2.RevCnt), 2);
            if (i == 30) chk("rev2.3", 32'(b2.RevCnt), 3);
            if (i == 40) chk("rev2.0", 32'(b2.RevCnt), 0);
        end
        chk("rev8.4", 32'(b.RevCnt), 4);

        // Mid-revolution asynchronous reset at index 7 with a sticky flag set.
        step(5'b01010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(jc(i), 1'b1, 1'b0);
        chk("pre.idx", 32'(b.PhaseIdx), 7);
        chk("pre.ill", 32'(b.IllegalErr), 1);
        #2 Reset = 1'b1;
        #1;
        chk_zero("async");
        @(negedge Clk);
        Reset = 1'b0;
        step(5'b10000, 1'b1, 1'b0);
        chk("first.idx",  32'(b.PhaseIdx), 9);
        chk("first.wrap", 32'(b.Wrap), 0);
        chk("first.step", 32'(b.StepErr), 0);
        step(5'b00000, 1'b1, 1'b0);
        chk("after.wrap", 32'(b.Wrap), 1);
        chk("after.rev",  32'(b.RevCnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 5-bit Johnson ring counter. It samples the counter's `Q[4:0]` state and registers three things: a one-hot 10-phase strobe vector and a binary phase index, a revolution counter, and sticky integrity flags. Downstream timing and strobe logic uses `Phase` directly. Fault monitoring reads the error flags.

## Interface
- `REV_W`, default 8: width of the revolution counter.

- `Clk`  in  1  clock; same domain as the upstream counter.
- `Reset`  in  1  reset, asynchronous, active-high.
- `Q_in`  in  5  Johnson state from the upstream counter (`Q[4:0]`).
- `En`  in  1  sample enable; when 0, all state and outputs hold.
- `ErrClr`  in  1  synchronous clear of the sticky error flags.
- `Phase`  out  10  one-hot phase vector, registered.
- `PhaseIdx`  out  4  binary phase index 0..9; 4'hF for an illegal code.
- `Valid`  out  1  last sampled code was legal.
- `Wrap`  out  1  one-cycle pulse on a 9→0 transition.
- `RevCnt`  out  `REV_W`  count of completed revolutions, modulo 2^`REV_W`.
- `IllegalErr`  out  1  sticky: an illegal code was sampled.
- `StepErr`  out  1  sticky: an out-of-sequence step was sampled (see Configuration).

## Operation
- Legal codes, `Q_in[4:0]` → index:
  - 00000→0, 00001→1, 00011→2, 00111→3, 01111→4
  - 11111→5, 11110→6, 11100→7, 11000→8, 10000→9
  - The other 22 codes are illegal.
- On a posedge `Clk` with `En`=1:
  - Legal code k: `Phase` = 1<<k, `PhaseIdx` = k, `Valid` = 1.
  - Illegal code: `Phase` = 0, `PhaseIdx` = 4'hF, `Valid` = 0, `IllegalErr` ← 1.
- Internal previous-sample register: holds the prior `PhaseIdx` and `Valid`; updated on every enabled edge.
- Wrap: `Wrap` = 1 for exactly one cycle when all of the following hold:
  - `En`=1,
  - the previous `Valid`=1 and previous index = 9,
  - the new code is legal with index 0.
  - On the same edge, `RevCnt` increments and wraps from 2^`REV_W`−1 to 0.
  - `Wrap` = 0 on every other edge, including edges with `En`=0.
- Step check (only with the macro defined):
  - Applies when `En`=1, the previous `Valid`=1 and the new code is legal.
  - Allowed new index: previous index, or (previous index + 1) mod 10.
  - Any other index sets `StepErr`.
  - No check on the first sample after reset, or on the first legal sample after an illegal one (resynchronisation).
- Sticky flags:
  - `ErrClr`=1 clears `IllegalErr` and `StepErr` on the edge.
  - If a new error occurs on the same edge, set wins and the flag stays 1.
  - `ErrClr` acts regardless of `En`.
- `En`=0: `Phase`, `PhaseIdx`, `Valid`, `RevCnt` and the previous-sample register all hold; `Wrap` = 0.

## Timing
- Latency: 1 cycle. `Q_in` sampled at edge n appears on the outputs after edge n.
- Reset (asynchronous, immediate) forces:
  - `Phase` = 10'b0, `PhaseIdx` = 0, `Valid` = 0, `Wrap` = 0,
  - `RevCnt` = 0, `IllegalErr` = 0, `StepErr` = 0,
  - previous-sample `Valid` = 0.
- Reset asserted mid-revolution: all state is lost. After release, the first enabled sample is treated as a first sample: no `Wrap`, no step check.
- With `En` tied high and a free-running upstream counter: `Phase` walks 1,2,4,…,512 and repeats. `Wrap` pulses once every 10 cycles, on the cycle in which `PhaseIdx` = 0.
- All outputs come from registers. There are no combinational paths from input to output.

## Configuration
- `JDEC_STEP_CHECK_EN`
  - Defined: the step-check logic and previous-index comparison are compiled in; `StepErr` behaves as specified above.
  - Undefined: the comparator is removed and `StepErr` is tied to 0. The port remains, and all other behaviour is unchanged.

## Test plan
- Reset, then 25 enabled cycles from a free-running upstream counter:
  - `PhaseIdx` sequence 0,1,…,9,0,…
  - `Wrap` pulses at cycles 10 and 20.
  - `RevCnt` = 2; both error flags remain 0.
- Inject `Q_in` = 5'b01010 for one enabled cycle:
  - next cycle `Phase` = 0, `PhaseIdx` = 4'hF, `Valid` = 0, `IllegalErr` = 1;
  - a following legal code 00111 gives `PhaseIdx` = 3 and `Valid` = 1, with `StepErr` still 0.
- With macro defined, sequence 00001 → 00111 (index 1→3):
  - `StepErr` = 1;
  - the same sequence built without the macro leaves `StepErr` = 0.
- Hold `En` = 0 for 4 cycles while `Q_in` changes: all outputs hold and `Wrap` = 0. Then sample 00011 twice with `En` = 1: index 2 repeated gives no `StepErr`.
- Set `REV_W` = 2 and run 4 revolutions: `RevCnt` goes 1,2,3,0.
- Error-flag timing:
  - `ErrClr` = 1 on the same edge as an illegal code: `IllegalErr` stays 1.
  - `ErrClr` on the next edge with a legal code: `IllegalErr` = 0.
- Assert `Reset` asynchronously mid-revolution at `PhaseIdx` = 7: all outputs go to 0 immediately. The first sample after release (code 10000, index 9) raises neither `StepErr` nor `Wrap`.
